// File: rtl/vector_mem_sequencer.sv
// Vector memory sequencer: splits VLDW/VLDH/VSTW/VSTH into LANES scalar memory beats.
// Optional misalignment check enabled by defining VEC_SEQ_ALIGN_CHECK_EN.
module vector_mem_sequencer #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_store,
    input  logic                  op_half,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LANES*32-1:0]   vec_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LANES*32-1:0]   vec_rdata,
    output logic                  vec_we,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StFin} state_t;

    state_t                state_q;
    logic [LW-1:0]         lane_q;
    logic                  store_q;
    logic                  half_q;
    logic [ADDR_W-1:0]     base_q;
    logic [LANES*32-1:0]   wdata_q;
    logic [LANES*32-1:0]   rbuf_q;

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic half,
                                                    input logic [LW-1:0] idx);
        logic [ADDR_W-1:0] a;
        a = base + (ADDR_W'(idx) << (half ? 1 : 2));
`ifndef VEC_SEQ_ALIGN_CHECK_EN
        a[0] = 1'b0;
        if (!half) a[1] = 1'b0;
`endif
        return a;
    endfunction

    function automatic logic [31:0] beat_wdata(input logic [LANES*32-1:0] vec,
                                               input logic half,
                                               input logic [LW-1:0] idx);
        logic [31:0] w;
        w = vec[32*int'(idx) +: 32];
        return half ? {w[15:0], w[15:0]} : w;
    endfunction

    // Next beat to present: lane 0 from the live inputs at start, else lane+1 from latched op.
    logic                  issue_store;
    logic                  issue_half;
    logic [ADDR_W-1:0]     issue_base;
    logic [LANES*32-1:0]   issue_vec;
    logic [LW-1:0]         issue_idx;
    logic [ADDR_W-1:0]     nxt_addr;
    logic [3:0]            nxt_be;
    logic [31:0]           nxt_wdata;
    logic [31:0]           load_elem;
    logic [LANES*32-1:0]   rbuf_upd;
    logic                  last_lane;

    always_comb begin
        issue_store = store_q;
        issue_half  = half_q;
        issue_base  = base_q;
        issue_vec   = wdata_q;
        issue_idx   = lane_q + 1'b1;
        if (state_q == StIdle) begin
            issue_store = op_store;
            issue_half  = op_half;
            issue_base  = base_addr;
            issue_vec   = vec_wdata;
            issue_idx   = '0;
        end
        nxt_addr  = beat_addr(issue_base, issue_half, issue_idx);
        nxt_be    = 4'b1111;
        nxt_wdata = '0;
        if (issue_store) begin
            nxt_wdata = beat_wdata(issue_vec, issue_half, issue_idx);
            if (issue_half) nxt_be = nxt_addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        load_elem = mem_rdata;
        if (half_q) load_elem = mem_addr[1] ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]};
        rbuf_upd = rbuf_q;
        rbuf_upd[32*int'(lane_q) +: 32] = load_elem;
    end

    assign last_lane = (lane_q == LW'(LANES - 1));
    assign busy      = start | (state_q != StIdle);

`ifdef VEC_SEQ_ALIGN_CHECK_EN
    logic err_q;
    logic misaligned;
    assign misaligned = op_half ? base_addr[0] : |base_addr[1:0];
    assign err        = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            lane_q    <= '0;
            store_q   <= 1'b0;
            half_q    <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
            vec_rdata <= '0;
            vec_we    <= 1'b0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
`ifdef VEC_SEQ_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            vec_we <= 1'b0;
`ifdef VEC_SEQ_ALIGN_CHECK_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (start) begin
                        store_q <= op_store;
                        half_q  <= op_half;
                        base_q  <= base_addr;
                        wdata_q <= vec_wdata;
                        lane_q  <= '0;
`ifdef VEC_SEQ_ALIGN_CHECK_EN
                        if (misaligned) begin
                            state_q <= StFin;
                            done    <= 1'b1;
                            err_q   <= 1'b1;
                        end else
`endif
                        begin
                            state_q   <= StReq;
                            mem_req   <= 1'b1;
                            mem_we    <= op_store;
                            mem_addr  <= nxt_addr;
                            mem_be    <= nxt_be;
                            mem_wdata <= nxt_wdata;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt) begin
                        if (!store_q) begin
                            state_q <= StWaitR;
                            mem_req <= 1'b0;
                        end else if (last_lane) begin
                            state_q <= StFin;
                            mem_req <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            lane_q    <= lane_q + 1'b1;
                            mem_addr  <= nxt_addr;
                            mem_be    <= nxt_be;
                            mem_wdata <= nxt_wdata;
                        end
                    end
                end
                StWaitR: begin
                    if (mem_rvalid) begin
                        rbuf_q <= rbuf_upd;
                        if (last_lane) begin
                            state_q   <= StFin;
                            done      <= 1'b1;
                            vec_we    <= 1'b1;
                            vec_rdata <= rbuf_upd;
                        end else begin
                            state_q   <= StReq;
                            lane_q    <= lane_q + 1'b1;
                            mem_req   <= 1'b1;
                            mem_addr  <= nxt_addr;
                            mem_be    <= nxt_be;
                            mem_wdata <= nxt_wdata;
                        end
                    end
                end
                StFin:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer: expected beats/vectors queued at issue,
// compared as the DUT presents beats and completes.
module tb_vector_mem_sequencer;

    localparam int LANES  = 4;
    localparam int ADDR_W = 32;
    localparam int VW     = LANES * 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              op_store;
    logic              op_half;
    logic [ADDR_W-1:0] base_addr;
    logic [VW-1:0]     vec_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [VW-1:0]     vec_rdata;
    logic              vec_we;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    vector_mem_sequencer #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_store(op_store), .op_half(op_half),
        .base_addr(base_addr), .vec_wdata(vec_wdata), .busy(busy), .done(done), .err(err),
        .vec_rdata(vec_rdata), .vec_we(vec_we), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    beat_t         beat_q[$];
    logic [VW-1:0] vec_q[$];
    logic [VW-1:0] last_vec = '0;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input bit half, input int i);
        logic [31:0] a;
        a = base + 32'(half ? 2 * i : 4 * i);
`ifndef VEC_SEQ_ALIGN_CHECK_EN
        a[0] = 1'b0;
        if (!half) a[1] = 1'b0;
`endif
        return a;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] pat, input bit vary, input int i);
        return pat ^ (vary ? 32'(i) * 32'h01010101 : 32'h0);
    endfunction

    task automatic push_op(input bit store, input bit half, input logic [31:0] base,
                           input logic [VW-1:0] wvec, input logic [31:0] rd_pat, input bit rd_vary);
        beat_t         b;
        logic [VW-1:0] v;
        logic [31:0]   w;
        logic [31:0]   rd;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            b.addr  = exp_addr(base, half, i);
            b.we    = store;
            b.be    = (store && half) ? (b.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            w       = wvec[32*i +: 32];
            b.wdata = half ? {w[15:0], w[15:0]} : w;
            beat_q.push_back(b);
            rd = rd_word(rd_pat, rd_vary, i);
            v[32*i +: 32] = half ? (b.addr[1] ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]}) : rd;
        end
        if (!store) vec_q.push_back(v);
    endtask

    task automatic run_op(input string tag, input bit store, input bit half, input logic [31:0] base,
                          input logic [VW-1:0] wvec, input logic [31:0] rd_pat, input bit rd_vary,
                          input int stall_lane, input int stall_cycles, input int rv_delay,
                          input int poke_cyc, input int abort_lane, input bit exp_err);
        int            cyc;
        int            beat;
        int            stall_left;
        int            rv_cnt;
        int            exp_done;
        bit            finished;
        beat_t         b;
        logic [VW-1:0] exp_vec;
        if (!exp_err) push_op(store, half, base, wvec, rd_pat, rd_vary);
        exp_done   = exp_err ? 1 : (store ? LANES + 1 : 2 * LANES + 1 + rv_delay * LANES);
        exp_done  += stall_cycles;
        beat       = 0;
        stall_left = stall_cycles;
        rv_cnt     = -1;
        finished   = 0;
        cyc        = 0;
        start      = 1'b1;
        op_store   = store;
        op_half    = half;
        base_addr  = base;
        vec_wdata  = wvec;
        #1 check({tag, " busy_start"}, busy, 1);
        @(negedge clk);
        cyc = 1;
        while (!finished) begin
            start = 1'b0;
            if (cyc == poke_cyc) begin
                start     = 1'b1;
                op_store  = ~store;
                base_addr = 32'h55;
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_word(rd_pat, rd_vary, beat - 1);
                rv_cnt     = -1;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
            end
            if (abort_lane >= 0 && mem_req && beat == abort_lane) begin
                rst = 1'b1;
                #1;
                check({tag, " rst_req"}, mem_req, 0);
                check({tag, " rst_busy"}, busy, 0);
                check({tag, " rst_vec"}, vec_rdata, 0);
                repeat (3) begin
                    @(negedge clk);
                    check({tag, " rst_done"}, done, 0);
                end
                rst = 1'b0;
                mem_rvalid = 1'b0;
                beat_q.delete();
                vec_q.delete();
                last_vec = '0;
                return;
            end
            check({tag, " busy"}, busy, 1);
            if (mem_req) begin
                if (beat_q.size() == 0) begin
                    check({tag, " extra_beat"}, 1, 0);
                    finished = 1;
                end else if (beat == stall_lane && stall_left > 0) begin
                    stall_left--;
                    if (!store) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = 32'hDEADBEEF;
                    end
                    check({tag, " stall_addr"}, mem_addr, beat_q[0].addr);
                end else begin
                    mem_gnt = 1'b1;
                    b = beat_q.pop_front();
                    check($sformatf("%s addr%0d", tag, beat), mem_addr, b.addr);
                    check($sformatf("%s we%0d", tag, beat), mem_we, b.we);
                    check($sformatf("%s be%0d", tag, beat), mem_be, b.be);
                    if (store) check($sformatf("%s wdata%0d", tag, beat), mem_wdata, b.wdata);
                    beat++;
                    if (!store) rv_cnt = rv_delay;
                end
            end
            if (done) begin
                check({tag, " done_cyc"}, cyc, exp_done);
                check({tag, " err"}, err, exp_err);
                check({tag, " vec_we"}, vec_we, !store && !exp_err);
                exp_vec = last_vec;
                if (!store && !exp_err && vec_q.size() > 0) exp_vec = vec_q.pop_front();
                check({tag, " vec_rdata"}, vec_rdata, exp_vec);
                check({tag, " beats_left"}, beat_q.size(), 0);
                last_vec = exp_vec;
                finished = 1;
            end
            if (!finished && cyc >= 200) begin
                check({tag, " timeout"}, 1, 0);
                finished = 1;
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        start      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " idle_done"}, done, 0);
        check({tag, " idle_req"}, mem_req, 0);
        beat_q.delete();
        vec_q.delete();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        op_store   = 1'b0;
        op_half    = 1'b0;
        base_addr  = '0;
        vec_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset req", mem_req, 0);
        check("reset done", done, 0);
        check("reset vec_we", vec_we, 0);
        check("reset err", err, 0);
        check("reset vec", vec_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("vstw", 1, 0, 32'h100,
               {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
               32'h0, 0, -1, 0, 0, -1, -1, 0);
        run_op("vldh", 0, 1, 32'h202, '0, 32'hAAAABBBB, 0, -1, 0, 0, -1, -1, 0);
        check("vldh lanes", last_vec,
              {32'h0000BBBB, 32'h0000AAAA, 32'h0000BBBB, 32'h0000AAAA});
        run_op("vldw_stall", 0, 0, 32'h300, '0, 32'h12345678, 1, 1, 3, 2, -1, -1, 0);
        run_op("vldw_abort", 0, 0, 32'h400, '0, 32'hCAFEF00D, 1, -1, 0, 0, -1, 2, 0);
        run_op("vldw_after", 0, 0, 32'h500, '0, 32'h0BADC0DE, 1, -1, 0, 0, -1, -1, 0);
        run_op("vsth_wrap", 1, 1, 32'hFFFFFFFC,
               {32'h0000D4D4, 32'h0000C3C3, 32'h0000B2B2, 32'h0000A1A1},
               32'h0, 0, -1, 0, 0, 2, -1, 0);
`ifdef VEC_SEQ_ALIGN_CHECK_EN
        run_op("vldw_misal", 0, 0, 32'h101, '0, 32'h0, 0, -1, 0, 0, -1, -1, 1);
        run_op("vsth_misal", 1, 1, 32'h201, '1, 32'h0, 0, -1, 0, 0, -1, -1, 1);
`else
        run_op("vstw_low", 1, 0, 32'h103,
               {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555},
               32'h0, 0, -1, 0, 0, -1, -1, 0);
        run_op("vldh_low", 0, 1, 32'h601, '0, 32'h9876FEDC, 1, -1, 0, 0, -1, -1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Multi-cycle sequencer for vector memory instructions: VLDW, VLDH, VSTW and VSTH.
- Decode raises start once per vector memory op. The block splits the op into LANES single-element memory beats on the scalar 32-bit data-memory port.
- It stalls the pipeline while active and delivers the assembled vector to the vector register file on completion.

Parameters:
LANES, 4, vector elements per register; power of two, 2..16
ADDR_W, 32, byte-address width of data memory

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  vector mem op issued; sampled only in IDLE
op_store  in  1  1=store (VSTW/VSTH), 0=load (VLDW/VLDH); sampled with start
op_half  in  1  1=halfword variant, 0=word; sampled with start
base_addr  in  ADDR_W  byte address of lane 0; sampled with start
vec_wdata  in  LANES*32  store source vector, lane i = bits [32i+31:32i]; sampled with start
busy  out  1  pipeline stall
done  out  1  one-cycle completion pulse
err  out  1  one-cycle misalignment pulse (optional feature only)
vec_rdata  out  LANES*32  loaded vector
vec_we  out  1  vector register file write enable
mem_req  out  1  memory request
mem_we  out  1  1=write beat
mem_addr  out  ADDR_W  beat byte address
mem_be  out  4  byte enables
mem_wdata  out  32  write data
mem_gnt  in  1  memory accepts current request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data

Behaviour:
- Clock and reset:
  - Single clock clk; rst is asynchronous, active-high.
  - On rst, the FSM goes to IDLE, the lane counter is 0 and all registered outputs are 0; vec_rdata is cleared to 0.
  - Reset mid-operation drops mem_req immediately and abandons the op; no done pulse follows.
- States: IDLE, REQ, WAIT_R, FIN.
- IDLE:
  - On start=1, latch op_store, op_half, base_addr and vec_wdata; lane=0; go to REQ.
- REQ:
  - mem_req=1, mem_we=op_store.
  - Word ops: mem_addr = base + 4*lane.
  - Half ops: mem_addr = base + 2*lane.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - Hold all outputs stable until mem_gnt=1.
  - On gnt, a store beat increments lane, then goes to REQ, or to FIN after lane LANES-1.
  - On gnt, a load beat goes to WAIT_R.
- WAIT_R:
  - mem_req=0. Wait for mem_rvalid; on rvalid, write lane register.
  - Word load: lane = mem_rdata.
  - Half load: lane = zero-extended mem_rdata[15:0] if mem_addr[1]=0, else mem_rdata[31:16].
  - Then lane++ and go to REQ, or to FIN after the last lane.
  - Exactly one outstanding read; mem_rvalid in any other state is ignored.
- FIN:
  - done=1 for one cycle; vec_we=1 in the same cycle for loads only; go to IDLE.
- Store byte enables and data:
  - Word: mem_be=4'b1111, mem_wdata = lane data.
  - Half: mem_be = 4'b0011 if addr[1]=0, else 4'b1100; mem_wdata = {lane[15:0], lane[15:0]}.
- Load enables: mem_be=4'b1111 for all loads.
- busy = start | (state != IDLE), combinational. The start cycle itself stalls; busy is 0 in the cycle after FIN.
- Ignored inputs: start while not IDLE is ignored; no queueing.
- vec_rdata holds its value until the next load's FIN.
- Latency with gnt tied 1 and rvalid one cycle after gnt, start at cycle 0:
  - Store: beats in cycles 1..LANES; done at cycle LANES+1.
  - Load: done at cycle 2*LANES+1.
- Memory stalls (gnt low, rvalid late) extend the op indefinitely; no timeout.

Optional Feature:
- Macro: VEC_SEQ_ALIGN_CHECK_EN.
- Defined:
  - At start, base_addr[1:0]!=0 (word op) or base_addr[0]!=0 (half op) skips all memory beats and goes directly to FIN.
  - err=1 and done=1 in that FIN cycle; vec_we=0; vec_rdata unchanged.
- Undefined:
  - No check; low address bits are forced to 0 in mem_addr (word: [1:0], half: [0]).
  - err is tied to 0.

Test Plan:
- Reset values: rst asserted mid-load at lane 2 -> mem_req=0 in the same cycle, busy=0, no done; the next start runs normally from lane 0.
- VSTW, LANES=4, base=0x100, lanes {0x11111111, 0x22222222, 0x33333333, 0x44444444}, gnt=1:
  - mem_addr 0x100/0x104/0x108/0x10C in cycles 1-4, mem_be=1111, wdata=lane i.
  - done at cycle 5; busy high in cycles 0-5.
- VLDH, base=0x202, mem returns 0xAAAABBBB at every beat, rvalid one cycle after gnt:
  - addrs 0x202/0x204/0x206/0x208.
  - vec_rdata lanes {0x0000AAAA, 0x0000BBBB, 0x0000AAAA, 0x0000BBBB}.
  - vec_we=done=1 at cycle 9.
- Handshake stall: VLDW with gnt held 0 for 3 cycles on lane 1, and rvalid delayed 2 cycles -> mem_addr/mem_req held stable; the extra rvalid pulse in REQ is ignored; lanes are correct.
- Address wrap and start-while-busy:
  - VSTH base=0xFFFFFFFC -> addrs 0xFFFFFFFC, 0xFFFFFFFE, 0x00000000, 0x00000002; be 0011/1100/0011/1100.
  - A second start at cycle 2 has no effect.
- VEC_SEQ_ALIGN_CHECK_EN:
  - VLDW at base 0x101 -> no mem_req; err=done=1 at cycle 1; vec_we=0.
  - With the macro undefined -> addresses 0x100..0x10C.
